// File: rtl/des_dec_key_sched_if.sv
// Handshake bundle between the DES decrypt key scheduler and its subkey consumer.
interface des_dec_key_sched_if;
  localparam int unsigned KEY_W    = 64;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUND_W  = 5;

  logic                start;
  logic [KEY_W-1:0]    key_in;
  logic                subkey_ready;
  logic                subkey_valid;
  logic [SUBKEY_W-1:0] subkey;
  logic [ROUND_W-1:0]  round_num;
  logic                busy;
  logic                done;

  modport master (
    output start, key_in, subkey_ready,
    input  subkey_valid, subkey, round_num, busy, done
  );

  modport slave (
    input  start, key_in, subkey_ready,
    output subkey_valid, subkey, round_num, busy, done
  );
endinterface

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key schedule: emits K16..K1, one subkey per valid/ready transfer.
// DES bit n (1 = MSB) of a W-bit vector lives at index W-n.
module des_dec_key_sched (
  input  logic                clk,
  input  logic                rst,
  des_dec_key_sched_if.slave  bus
);
  localparam int unsigned KEY_W    = 64;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUND_W  = 5;

  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] o;
    o = '0;
    for (int j = 0; j < int'(CD_W); j++)
      o[6'(int'(CD_W) - 1 - j)] = k[6'(int'(KEY_W) - int'(PC1_TBL[j]))];
    return o;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] o;
    o = '0;
    for (int j = 0; j < int'(SUBKEY_W); j++)
      o[6'(int'(SUBKEY_W) - 1 - j)] = cd[6'(int'(CD_W) - int'(PC2_TBL[j]))];
    return o;
  endfunction

  // Right rotate undoes the encryption-side left shift for the round being left.
  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  state_t              r_state;
  logic [HALF_W-1:0]   r_c;
  logic [HALF_W-1:0]   r_d;
  logic [ROUND_W-1:0]  r_round;
  logic [SUBKEY_W-1:0] r_subkey;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  logic [CD_W-1:0]     w_pc1;
  logic                w_shift2;
  logic [HALF_W-1:0]   w_c_rot;
  logic [HALF_W-1:0]   w_d_rot;
  logic [SUBKEY_W-1:0] w_subkey_rot;

  assign w_pc1        = pc1(bus.key_in);
  assign w_shift2     = !((r_round == 5'd1) || (r_round == 5'd2) ||
                          (r_round == 5'd9) || (r_round == 5'd16));
  assign w_c_rot      = rotr(r_c, w_shift2);
  assign w_d_rot      = rotr(r_d, w_shift2);
  assign w_subkey_rot = pc2({w_c_rot, w_d_rot});

  // K16 comes straight from C0D0: the full schedule rotates each half by 28.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_c      <= '0;
      r_d      <= '0;
      r_round  <= '0;
      r_subkey <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_c      <= w_pc1[CD_W-1:HALF_W];
            r_d      <= w_pc1[HALF_W-1:0];
            r_subkey <= pc2(w_pc1);
            r_round  <= 5'd16;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (bus.subkey_ready) begin
            if (r_round == 5'd1) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_c      <= w_c_rot;
              r_d      <= w_d_rot;
              r_subkey <= w_subkey_rot;
              r_round  <= r_round - 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.subkey_valid = r_valid;
  assign bus.subkey       = r_subkey;
  assign bus.round_num    = r_round;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
endmodule

// File: doc/des_dec_key_sched.md
# des_dec_key_sched

Iterative DES key scheduler for the decryption direction: it accepts a 64-bit DES key and emits the sixteen 48-bit round subkeys in reverse order (K16 first, K1 last), one per valid/ready handshake. It computes PC-1 once, then rotates the C/D halves right, undoing the encryption-side left rotations. It sits between the key register and the iterative Feistel round datapath (which uses the S-box lookups) when the core runs in decrypt mode. Bit numbering follows the DES standard: bit 1 is the MSB.

## Interface
- No parameters. Shift schedule, PC-1 and PC-2 are fixed by FIPS 46-3.
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new schedule; sampled only in IDLE
- key_in  input  [64:1]  DES key incl. parity bits (bits 8,16,…,64 ignored by PC-1); sampled on accepted start
- subkey_ready  input  1  consumer accepts the current subkey
- subkey_valid  output  1  subkey is valid
- subkey  output  [48:1]  PC-2(C,D) for round round_num
- round_num  output  [4:0]  DES round index of the current subkey (16 down to 1)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after K1 is transferred

## Operation
- Registers: C[28:1], D[28:1], round counter, state, registered subkey/round_num.
- Shift table, by round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- States: IDLE, EMIT.
- IDLE:
  - subkey_valid=0, busy=0.
  - If start=1: C,D <= PC-1(key_in); subkey <= PC-2(PC-1(key_in)); round_num <= 16; go to EMIT.
  - K16 uses the unrotated C0D0 because the total left shift is 28, a full rotation.
- EMIT:
  - subkey_valid=1, busy=1.
  - Transfer occurs when subkey_valid && subkey_ready.
  - Transfer with round_num=r>1: C,D each rotate right by shift[r]; subkey <= PC-2 of the rotated value; round_num <= r-1.
  - Transfer with round_num=1: go to IDLE; done=1 for exactly that next cycle. C/D are not rotated further.
- Backpressure: while subkey_valid && !subkey_ready, subkey, round_num, C and D hold unchanged.
- start during EMIT is ignored, and key_in is not resampled.
- start in the cycle done=1 is accepted, since state is IDLE then.
- C and D rotate independently (28-bit each). A right rotate by 2 maps bit i to bit i+2, wrapping within the half.

## Timing
- Reset values: subkey_valid=0, subkey=0, round_num=0, busy=0, done=0, state=IDLE, C=D=0.
- rst wins over all other inputs.
- Reset mid-schedule aborts with no done pulse; the next start begins a fresh schedule.
- Latency: start accepted at edge N → K16 valid from cycle N+1.
- With subkey_ready tied high, one subkey per cycle: K1 in cycle N+16, done in cycle N+17, busy low from N+17.
- All outputs are registered; there is no combinational path from subkey_ready or start to any output.
- done and subkey_valid are never high in the same cycle.

## Test plan
- Reset: assert rst 2 cycles with start=1 → all outputs 0; IDLE held until start is asserted after rst deasserts.
- Standard vector, key_in=0x133457799BBCDFF1, subkey_ready=1:
  - cycle N+1: subkey=0xCB3D8B0E17F5, round_num=16.
  - cycle N+16: subkey=0x1B02EFFC7072, round_num=1.
  - cycle N+17: done=1.
  - All 16 subkeys must equal the encryption-order subkeys from a reference model, reversed.
- Backpressure: same key, subkey_ready low for 3 cycles at round_num=12 → subkey/round_num stable for 3 cycles; sequence afterwards identical; done delayed by exactly 3 cycles.
- start while busy: pulse start with key_in=0xFFFFFFFFFFFFFFFF at round_num=8 → sequence for 0x133457799BBCDFF1 continues unchanged.
- Reset mid-op: rst at round_num=5 → next cycle subkey_valid=0, busy=0, no done pulse. New start → K16 again in 1 cycle.
- Back-to-back: start asserted in the done cycle with key_in=0x0000000000000000 → next cycle subkey=0x000000000000, round_num=16; all 16 subkeys 0.
